// File: rtl/frame_buffer_arb.sv
// rtl/frame_buffer_arb.sv - single-frame pixel store with writer/reader session arbitration
//
// Holds one frame of `depth` 15-bit pixels and hands out exclusive sessions
// to one writer and one reader. A frame must be completely written before it
// can be read, and must be read (consumed) before a new frame is accepted.
//
// Optional feature macro: FB_OVERWRITE_EN
//   defined   - an idle buffer holding an unread frame may still be granted
//               to the writer when no read is requested; the old frame is
//               dropped at grant.
//   undefined - the writer waits until the stored frame has been consumed.
//
// Ports
//   buffer_clk      in   sole clock, rising edge
//   reset           in   synchronous, active-high
//   write_clk       in   write strobe; each 0->1 transition requests one write
//   input_px_data   in   pixel to write
//   write_addr      in   write address (>= depth ignored)
//   enable_mem      in   qualifies a write strobe
//   rq_write        in   writer requests a session
//   writing         in   writer session active (level)
//   ack_write       out  write session granted
//   rq_read         in   reader requests a session
//   reading         in   reader session active (level)
//   ack_read        out  read session granted
//   read_clk        in   read strobe; each 0->1 transition fetches one word
//   read_addr       in   read address (>= depth reads as 0)
//   output_px_data  out  registered read data
//   frame_valid     out  a complete unread frame is stored

module frame_buffer_arb #(
    parameter int  depth = 76800,
    localparam int AW    = $clog2(depth)
) (
    input  logic          buffer_clk,
    input  logic          reset,
    input  logic          write_clk,
    input  logic [14:0]   input_px_data,
    input  logic [AW-1:0] write_addr,
    input  logic          enable_mem,
    input  logic          rq_write,
    input  logic          writing,
    output logic          ack_write,
    input  logic          rq_read,
    input  logic          reading,
    output logic          ack_read,
    input  logic          read_clk,
    input  logic [AW-1:0] read_addr,
    output logic [14:0]   output_px_data,
    output logic          frame_valid
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(depth - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t        state_q;
    logic          ack_write_q;
    logic          ack_read_q;
    logic          frame_valid_q;

    // Session handshake inputs are sampled once before the arbiter acts on
    // them, so grant and release both land one cycle after the sampling edge.
    logic          rq_write_q;
    logic          rq_read_q;
    logic          writing_q;
    logic          reading_q;

    // Strobe history for rising-edge detection.
    logic          wr_strobe_q;
    logic          rd_strobe_q;

    // Read pipeline: request captured on the strobe edge, data on the next.
    logic          rd_pend_q;
    logic [AW-1:0] rd_addr_q;
    logic [14:0]   rd_data_q;
    logic [14:0]   rd_data_d;

    logic [14:0]   mem_q [depth];

    logic          wr_edge;
    logic          rd_edge;
    logic          wr_fire;
    logic          rd_fire;
    logic          wr_grant_ok;

    assign wr_edge = write_clk & ~wr_strobe_q;
    assign rd_edge = read_clk  & ~rd_strobe_q;

    // The writer may only touch memory while it holds the grant and says it
    // is writing; out-of-range addresses are dropped here.
    assign wr_fire = wr_edge & enable_mem & writing & ack_write_q & ~reset
                   & (write_addr <= LAST_ADDR);

    assign rd_fire = rd_edge & ack_read_q & ~reset;

`ifdef FB_OVERWRITE_EN
    assign wr_grant_ok = ~frame_valid_q | ~rq_read_q;
`else
    assign wr_grant_ok = ~frame_valid_q;
`endif

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_pend_q) begin
            rd_data_d = (rd_addr_q <= LAST_ADDR) ? mem_q[rd_addr_q] : '0;
        end
    end

    // Pixel storage is deliberately left out of reset.
    always_ff @(posedge buffer_clk) begin
        if (wr_fire) begin
            mem_q[write_addr] <= input_px_data;
        end
    end

    always_ff @(posedge buffer_clk) begin
        if (reset) begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            rq_write_q  <= 1'b0;
            rq_read_q   <= 1'b0;
            writing_q   <= 1'b0;
            reading_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
        end else begin
            wr_strobe_q <= write_clk;
            rd_strobe_q <= read_clk;
            rq_write_q  <= rq_write;
            rq_read_q   <= rq_read;
            writing_q   <= writing;
            reading_q   <= reading;
            rd_pend_q   <= rd_fire;
            if (rd_fire) begin
                rd_addr_q <= read_addr;
            end
            rd_data_q   <= rd_data_d;
        end
    end

    // Arbiter. Acks are registered outputs of this block and are only ever
    // set from IDLE, so they can never be high together.
    always_ff @(posedge buffer_clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ack_write_q   <= 1'b0;
            ack_read_q    <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A pending read of a finished frame takes priority.
                    if (rq_read_q && frame_valid_q) begin
                        state_q    <= ST_READ;
                        ack_read_q <= 1'b1;
                    end else if (rq_write_q && wr_grant_ok) begin
                        state_q       <= ST_WRITE;
                        ack_write_q   <= 1'b1;
                        frame_valid_q <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (!rq_write_q && !writing_q) begin
                        state_q       <= ST_IDLE;
                        ack_write_q   <= 1'b0;
                        frame_valid_q <= 1'b1;
                    end
                end
                ST_READ: begin
                    // Ending the session consumes the frame whether or not
                    // any pixel was fetched.
                    if (!rq_read_q && !reading_q) begin
                        state_q       <= ST_IDLE;
                        ack_read_q    <= 1'b0;
                        frame_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    ack_write_q <= 1'b0;
                    ack_read_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_write      = ack_write_q;
    assign ack_read       = ack_read_q;
    assign frame_valid    = frame_valid_q;
    assign output_px_data = rd_data_q;

endmodule

// File: tb/tb_frame_buffer_arb.sv
// tb/tb_frame_buffer_arb.sv - directed self-checking bench for frame_buffer_arb

module tb_frame_buffer_arb;

    localparam int AW = 17;

    logic          buffer_clk = 1'b0;
    logic          reset;
    logic          write_clk;
    logic [14:0]   input_px_data;
    logic [AW-1:0] write_addr;
    logic          enable_mem;
    logic          rq_write;
    logic          writing;
    logic          ack_write;
    logic          rq_read;
    logic          reading;
    logic          ack_read;
    logic          read_clk;
    logic [AW-1:0] read_addr;
    logic [14:0]   output_px_data;
    logic          frame_valid;

    int n_checks = 0;
    int n_pass   = 0;

    frame_buffer_arb dut (
        .buffer_clk     (buffer_clk),
        .reset          (reset),
        .write_clk      (write_clk),
        .input_px_data  (input_px_data),
        .write_addr     (write_addr),
        .enable_mem     (enable_mem),
        .rq_write       (rq_write),
        .writing        (writing),
        .ack_write      (ack_write),
        .rq_read        (rq_read),
        .reading        (reading),
        .ack_read       (ack_read),
        .read_clk       (read_clk),
        .read_addr      (read_addr),
        .output_px_data (output_px_data),
        .frame_valid    (frame_valid)
    );

    always #5 buffer_clk = ~buffer_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge buffer_clk);
            #1;
        end
    endtask

    task automatic wr_px(input logic [AW-1:0] a, input logic [14:0] d, input logic en);
        write_addr    = a;
        input_px_data = d;
        enable_mem    = en;
        write_clk     = 1'b1;
        tick(1);
        write_clk     = 1'b0;
        tick(1);
    endtask

    task automatic rd_px(input string tag, input logic [AW-1:0] a, input logic [14:0] exp);
        read_addr = a;
        read_clk  = 1'b1;
        tick(1);
        read_clk  = 1'b0;
        tick(1);
        check(tag, 32'(output_px_data), 32'(exp));
    endtask

    task automatic open_write(input string tag);
        rq_write = 1'b1;
        tick(2);
        check(tag, 32'(ack_write), 32'd1);
        writing  = 1'b1;
        rq_write = 1'b0;
        tick(1);
    endtask

    task automatic close_write(input string tag);
        writing = 1'b0;
        tick(2);
        check({tag, "_ack"}, 32'(ack_write), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd1);
    endtask

    task automatic open_read(input string tag);
        rq_read = 1'b1;
        tick(2);
        check(tag, 32'(ack_read), 32'd1);
        reading = 1'b1;
        rq_read = 1'b0;
        tick(1);
    endtask

    task automatic close_read(input string tag);
        reading = 1'b0;
        tick(2);
        check({tag, "_ack"}, 32'(ack_read), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; write_clk = 1'b0; input_px_data = '0; write_addr = '0;
        enable_mem = 1'b1; rq_write = 1'b0; writing = 1'b0; rq_read = 1'b0;
        reading = 1'b0; read_clk = 1'b0; read_addr = '0;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("rst_ack_write", 32'(ack_write), 32'd0);
        check("rst_ack_read", 32'(ack_read), 32'd0);
        check("rst_data", 32'(output_px_data), 32'd0);
        check("rst_fv", 32'(frame_valid), 32'd0);

        // No frame stored: a read request is not granted.
        rq_read = 1'b1;
        tick(4);
        check("no_frame_read", 32'(ack_read), 32'd0);
        rq_read = 1'b0;
        tick(2);

        // Frame A: corner addresses; a disabled strobe must not overwrite.
        open_write("a_grant");
        check("a_excl", 32'(ack_read), 32'd0);
        wr_px(17'd0, 15'h7FFF, 1'b1);
        wr_px(17'd76799, 15'h1234, 1'b1);
        wr_px(17'd0, 15'h2222, 1'b0);
        close_write("a_rel");

`ifndef FB_OVERWRITE_EN
        // Unread frame present: the writer must wait.
        rq_write = 1'b1;
        tick(4);
        check("wr_blocked", 32'(ack_write), 32'd0);
        rq_write = 1'b0;
        tick(2);
`endif

        // Strobe without a grant is ignored.
        writing = 1'b1;
        wr_px(17'd0, 15'h1111, 1'b1);
        writing = 1'b0;
        tick(2);

        open_read("a_rd_grant");
        rd_px("a_rd0", 17'd0, 15'h7FFF);
        rd_px("a_rd_last", 17'd76799, 15'h1234);
        close_read("a_rd_rel");
        // Read outside a session leaves the output register alone.
        rd_px("rd_no_sess", 17'd0, 15'h1234);

        // Frame B consumed by a one-cycle reading pulse.
        open_write("b_grant");
        wr_px(17'd100, 15'h0155, 1'b1);
        close_write("b_rel");
        rq_read = 1'b1;
        tick(2);
        check("pulse_grant", 32'(ack_read), 32'd1);
        reading = 1'b1;
        rq_read = 1'b0;
        tick(1);
        reading = 1'b0;
        tick(2);
        check("pulse_ack", 32'(ack_read), 32'd0);
        check("pulse_fv", 32'(frame_valid), 32'd0);

        // Frame C, then simultaneous requests: read wins, write waits.
        open_write("c_grant");
        wr_px(17'd200, 15'h0AAA, 1'b1);
        close_write("c_rel");
        rq_read  = 1'b1;
        rq_write = 1'b1;
        tick(2);
        check("both_rd", 32'(ack_read), 32'd1);
        check("both_wr", 32'(ack_write), 32'd0);
        reading = 1'b1;
        rq_read = 1'b0;
        tick(3);
        check("both_wr_wait", 32'(ack_write), 32'd0);
        rd_px("c_rd", 17'd200, 15'h0AAA);
        close_read("c_rd_rel");
        tick(2);
        check("wr_after_rd", 32'(ack_write), 32'd1);

        // Reset in the middle of a write session.
        writing  = 1'b1;
        rq_write = 1'b0;
        tick(1);
        wr_px(17'd300, 15'h0444, 1'b1);
        reset = 1'b1;
        tick(1);
        check("mid_rst_ack_w", 32'(ack_write), 32'd0);
        check("mid_rst_ack_r", 32'(ack_read), 32'd0);
        check("mid_rst_fv", 32'(frame_valid), 32'd0);
        check("mid_rst_data", 32'(output_px_data), 32'd0);
        reset   = 1'b0;
        writing = 1'b0;
        tick(2);

        // Frame D: out-of-range write dropped; storage survives reset.
        open_write("d_grant");
        wr_px(17'd80000, 15'h3333, 1'b1);
        wr_px(17'd7, 15'h0777, 1'b1);
        close_write("d_rel");
        open_read("d_rd_grant");
        rd_px("d_rd_oor", 17'd80000, 15'h0000);
        rd_px("d_rd7", 17'd7, 15'h0777);
        rd_px("d_rd_keep", 17'd76799, 15'h1234);
        rd_px("d_rd300", 17'd300, 15'h0444);
        close_read("d_rd_rel");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
